note_length_player: RTL and testbench

NOTE_LENGTH_PLAYER -- requirements
Module: note_length_player

---
 rtl/note_length_player.sv | 168 ++++++++++++++++
 tb/tb_note_length_player.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_length_player.sv
// -----------------------------------------------------------------------------
// note_length_player
//
// Plays a stream of notes whose lengths (1..4 beats) come from an external
// LFSR length generator. Each note is followed by a fixed-length rest (gap).
// A run begins on start in IDLE and continues note after note until stop
// is seen. Stop never truncates the note or gap currently in progress.
//
// Sequence per note: FETCH (request a new random code) -> LATCH (capture it)
// -> PLAY (len beats) -> GAP (rest) -> FETCH again or IDLE.
//
// Handshake: enable_rand is a one-cycle advance request. rand_length must
// hold the new code by the following (LATCH) cycle. No ready/back-pressure.
//
// Ports
//   clk         in   single rising-edge clock
//   reset       in   synchronous active-high reset
//   start       in   level; begins a run when sampled high in IDLE
//   stop        in   level; clears the run flag in any state
//   rand_length in   2-bit length code (note length = code + 1 beats)
//   enable_rand out  one-cycle advance request to the LFSR (FETCH)
//   note_on     out  high while a note sounds (PLAY)
//   note_done   out  one-cycle pulse in the first GAP cycle
//   beats_left  out  beats remaining in the current note, incl. current beat
//   note_count  out  notes completed since reset, wraps 255 -> 0
//   busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module note_length_player #(
   parameter int TICKS_PER_BEAT = 12500000,
   parameter int GAP_TICKS      = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic [1:0] rand_length,
   output logic       enable_rand,
   output logic       note_on,
   output logic       note_done,
   output logic [2:0] beats_left,
   output logic [7:0] note_count,
   output logic       busy
);

   // One tick counter serves both PLAY and GAP, so it is sized for the
   // longer of the two intervals.
   localparam int MAX_TICKS = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
   localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
   localparam logic [CW-1:0] BEAT_LAST = CW'(TICKS_PER_BEAT - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      PLAY  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          run;
   logic [CW-1:0] tick;
   logic          beat_end;
   logic          gap_end;
   logic          run_next;

   assign beat_end = (tick == BEAT_LAST);
   assign gap_end  = (tick == GAP_LAST);
   // A stop seen on the very last gap cycle still ends the run.
   assign run_next = run & ~stop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and Moore outputs
   always_comb begin
      state_next  = state;
      enable_rand = 1'b0;
      note_on     = 1'b0;
      note_done   = 1'b0;
      busy        = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start && !stop) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            enable_rand = 1'b1;
            state_next  = LATCH;
         end
         LATCH: begin
            state_next = PLAY;
         end
         PLAY: begin
            note_on = 1'b1;
            if (beat_end && (beats_left == 3'd1)) begin
               state_next = GAP;
            end
         end
         GAP: begin
            // The tick counter enters GAP at zero and only returns to zero
            // on leaving, so tick==0 marks the first gap cycle.
            note_done = (tick == '0);
            if (gap_end) begin
               state_next = run_next ? FETCH : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Run flag, tick counter, beat counter, note counter
   always_ff @(posedge clk) begin
      if (reset) begin
         run        <= 1'b0;
         tick       <= '0;
         beats_left <= 3'd0;
         note_count <= 8'd0;
      end else begin
         if (stop) begin
            run <= 1'b0;
         end else if ((state == IDLE) && start) begin
            run <= 1'b1;
         end

         case (state)
            LATCH: begin
               tick       <= '0;
               beats_left <= {1'b0, rand_length} + 3'd1;
            end
            PLAY: begin
               if (beat_end) begin
                  tick       <= '0;
                  beats_left <= beats_left - 3'd1;
                  if (beats_left == 3'd1) begin
                     note_count <= note_count + 8'd1;
                  end
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            GAP: begin
               if (gap_end) begin
                  tick <= '0;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: begin
               tick       <= '0;
               beats_left <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_length_player.sv
// -----------------------------------------------------------------------------
// tb_note_length_player
//
// Bench for note_length_player with TICKS_PER_BEAT=4, GAP_TICKS=2.
// The driver pushes the expected note length (in clk cycles) into exp_q when
// it launches a note; a negedge monitor measures each note_on pulse, pops the
// queue and compares, and also checks beats_left and note_done every cycle.
// -----------------------------------------------------------------------------
module tb_note_length_player;

   localparam int TPB = 4;
   localparam int GAP = 2;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] rand_length = 2'd0;
   logic       enable_rand;
   logic       note_on;
   logic       note_done;
   logic [2:0] beats_left;
   logic [7:0] note_count;
   logic       busy;

   always #5 clk = ~clk;

   note_length_player #(
      .TICKS_PER_BEAT(TPB),
      .GAP_TICKS     (GAP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .rand_length(rand_length),
      .enable_rand(enable_rand),
      .note_on    (note_on),
      .note_done  (note_done),
      .beats_left (beats_left),
      .note_count (note_count),
      .busy       (busy)
   );

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int en_count = 0;
   int on_len = 0;
   logic prev_on = 1'b0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: samples mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         on_len  = 0;
         prev_on = 1'b0;
      end else begin
         // note_done pulses exactly on the first cycle after note_on falls
         chk("note_done_timing", int'(note_done), int'(prev_on & ~note_on));
         if (note_on) begin
            if (exp_q.size() == 0) begin
               chk("note_unexpected", 1, 0);
            end else begin
               chk("beats_left_play", int'(beats_left), int'(exp_q[0]) / TPB - on_len / TPB);
            end
            on_len++;
         end else begin
            chk("beats_left_rest", int'(beats_left), 0);
            if (on_len > 0) begin
               if (exp_q.size() == 0) begin
                  chk("note_len_noexp", on_len, 0);
               end else begin
                  chk("note_len", on_len, int'(exp_q.pop_front()));
               end
               on_len = 0;
            end
         end
         if (enable_rand) en_count++;
         prev_on = note_on;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         step(1);
         n++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   typedef struct {
      logic [1:0] code;
      int         exp_len;
      int         exp_count;
   } vec_t;

   vec_t vecs[6];

   // ---------------- test ----------------
   initial begin
      int en0;
      int n;
      logic [1:0] r;

      // table of single notes, run from IDLE with stop raised after launch
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: r = 2'd0;
            1: r = 2'd3;
            2: r = 2'd1;
            3: r = 2'd2;
            default: r = 2'($urandom_range(0, 3));
         endcase
         vecs[i].code      = r;
         vecs[i].exp_len   = (int'(r) + 1) * TPB;
         vecs[i].exp_count = i + 2;
      end

      // reset state
      reset = 1'b1;
      step(2);
      chk("rst_enable_rand", int'(enable_rand), 0);
      chk("rst_note_on", int'(note_on), 0);
      chk("rst_note_done", int'(note_done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_beats_left", int'(beats_left), 0);
      chk("rst_note_count", int'(note_count), 0);
      reset = 1'b0;
      step(1);

      // single note, code 2 -> 12 cycles; start sampled at cycle 0
      en0 = en_count;
      rand_length = 2'd2;
      start = 1'b1;
      exp_q.push_back(8'(3 * TPB));
      step(1);                                   // cycle 1: FETCH
      chk("c1_enable_rand", int'(enable_rand), 1);
      chk("c1_busy", int'(busy), 1);
      chk("c1_note_on", int'(note_on), 0);
      start = 1'b0;
      stop  = 1'b1;
      step(1);                                   // cycle 2: LATCH
      chk("c2_enable_rand", int'(enable_rand), 0);
      chk("c2_note_on", int'(note_on), 0);
      step(1);                                   // cycle 3: first PLAY
      chk("c3_note_on", int'(note_on), 1);
      chk("c3_beats_left", int'(beats_left), 3);
      step(11);                                  // cycle 14: last PLAY
      chk("c14_note_on", int'(note_on), 1);
      chk("c14_beats_left", int'(beats_left), 1);
      step(1);                                   // cycle 15: first GAP
      chk("c15_note_on", int'(note_on), 0);
      chk("c15_note_done", int'(note_done), 1);
      step(1);                                   // cycle 16
      chk("c16_note_done", int'(note_done), 0);
      chk("c16_note_count", int'(note_count), 1);
      chk("c16_busy", int'(busy), 1);
      step(1);                                   // cycle 17: IDLE
      chk("c17_busy", int'(busy), 0);
      step(4);
      chk("single_enable_count", en_count - en0, 1);
      stop = 1'b0;

      // table-driven length bounds
      for (int i = 0; i < 6; i++) begin
         rand_length = vecs[i].code;
         start = 1'b1;
         stop  = 1'b0;
         exp_q.push_back(8'(vecs[i].exp_len));
         step(1);
         start = 1'b0;
         stop  = 1'b1;
         wait_idle(100);
         chk("table_note_count", int'(note_count), vecs[i].exp_count);
      end
      stop = 1'b0;

      // continuous run: 8 on, gap 2, FETCH, LATCH
      en0 = en_count;
      rand_length = 2'd1;
      start = 1'b1;
      exp_q.push_back(8'(2 * TPB));
      step(3);                                   // first PLAY cycle
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 12; k++) begin
            if (k == 0) exp_q.push_back(8'(2 * TPB));
            chk("run_note_on", int'(note_on), int'(k < 8));
            chk("run_note_done", int'(note_done), int'(k == 8));
            chk("run_enable_rand", int'(enable_rand), int'(k == 10));
            step(1);
         end
      end
      stop = 1'b1;                               // 4th note is playing
      wait_idle(60);
      chk("run_enable_count", en_count - en0, 4);
      chk("run_note_count", int'(note_count), 11);
      // start and stop both high in IDLE: stop wins
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("prio_busy", int'(busy), 0);
      end
      chk("prio_enable_count", en_count - en0, 4);
      start = 1'b0;
      stop  = 1'b0;

      // reset at the 5th PLAY cycle
      rand_length = 2'd3;
      start = 1'b1;
      exp_q.push_back(8'(4 * TPB));
      step(1);
      start = 1'b0;
      step(2);                                   // 1st PLAY cycle
      chk("rmid_note_on", int'(note_on), 1);
      step(4);                                   // 5th PLAY cycle
      reset = 1'b1;
      exp_q.delete();
      step(1);
      chk("rmid_note_on_after", int'(note_on), 0);
      chk("rmid_busy", int'(busy), 0);
      chk("rmid_note_count", int'(note_count), 0);
      chk("rmid_note_done", int'(note_done), 0);
      reset = 1'b0;
      step(1);
      chk("rmid_note_done2", int'(note_done), 0);
      chk("rmid_busy2", int'(busy), 0);
      chk("rmid_note_count2", int'(note_count), 0);

      // 256 notes -> note_count wraps to 0
      rand_length = 2'd0;
      for (int i = 0; i < 256; i++) exp_q.push_back(8'(TPB));
      start = 1'b1;
      step(1);
      start = 1'b0;
      n = 0;
      while (!(note_on && note_count == 8'd255) && n < 4000) begin
         step(1);
         n++;
      end
      chk("wrap_timeout", int'(n < 4000), 1);
      stop = 1'b1;
      wait_idle(50);
      chk("wrap_note_count", int'(note_count), 0);
      stop = 1'b0;

      step(2);
      chk("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
